// File: rtl/traffic_timing_loader.sv
// traffic_timing_loader: collects six BCD keypad digits (Tpv, Tsv, Ta as
// tens/units pairs), range-checks the three times, waits for a safe point
// from the semaphore controller, then writes the digits one-hot into the
// timing register bank.
// Optional build macro: CFG_ENTRY_TIMEOUT_EN adds an idle-cycle watchdog
// during digit entry (limit ENTRY_TIMEOUT cycles).
module traffic_timing_loader #(
   parameter int unsigned MIN_TIME      = 5,
   parameter int unsigned MAX_TIME      = 99,
   parameter int unsigned ENTRY_TIMEOUT = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmdStart,
   input  logic       cmdAbort,
   input  logic       digitValid,
   input  logic [3:0] dataIn,
   input  logic       commitAllowed,
   output logic [5:0] RegisterSelect,
   output logic [3:0] dataOut,
   output logic       busy,
   output logic [1:0] stage,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_WAIT_SAFE,
      S_WRITE,
      S_ERROR
   } state_t;

   localparam logic [6:0] MIN_T = 7'(MIN_TIME);
   localparam logic [6:0] MAX_T = 7'(MAX_TIME);

   // Reject nonsensical configurations at elaboration time.
   if (MIN_TIME > MAX_TIME || MAX_TIME > 99 || ENTRY_TIMEOUT < 1) begin : g_bad_cfg
      $error("traffic_timing_loader: invalid MIN_TIME/MAX_TIME/ENTRY_TIMEOUT");
   end

   // Two BCD digits to a binary seconds value (max 99, fits in 7 bits).
   function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] units);
      return (7'(tens) * 7'd10) + 7'(units);
   endfunction

   function automatic logic in_range(input logic [6:0] v);
      return (v >= MIN_T) && (v <= MAX_T);
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  wr_idx_q, wr_idx_d;
   logic [3:0]  shadow_q [6];
   logic [3:0]  shadow_d [6];
   logic [5:0]  sel_q, sel_d;
   logic [3:0]  dout_q, dout_d;
   logic        busy_q, busy_d;
   logic [1:0]  stage_q, stage_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        range_ok;

`ifdef CFG_ENTRY_TIMEOUT_EN
   localparam int TMO_W = $clog2(ENTRY_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ENTRY_TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Shadow slots are ordered like RegisterSelect bits: 0=Tpv tens ... 5=Ta units.
   assign range_ok = in_range(bcd_value(shadow_q[0], shadow_q[1])) &&
                     in_range(bcd_value(shadow_q[2], shadow_q[3])) &&
                     in_range(bcd_value(shadow_q[4], shadow_q[5]));

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_idx_d = wr_idx_q;
      shadow_d = shadow_q;
      sel_d    = 6'd0;
      dout_d   = 4'd0;
      done_d   = 1'b0;
      error_d  = error_q;
      stage_d  = stage_q;
`ifdef CFG_ENTRY_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Start beats a simultaneous abort; stray digits are ignored here.
            if (cmdStart) begin
               state_d = S_ENTRY;
               error_d = 1'b0;
               cnt_d   = 3'd0;
               stage_d = 2'd0;
`ifdef CFG_ENTRY_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         S_ENTRY: begin
            if (cmdAbort) begin
               state_d = S_IDLE;
            end else if (digitValid) begin
`ifdef CFG_ENTRY_TIMEOUT_EN
               tmo_d = '0;
`endif
               if (dataIn > 4'd9) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end else begin
                  shadow_d[cnt_q] = dataIn;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd5) begin
                     state_d = S_CHECK;
                  end else begin
                     stage_d = cnt_d[2:1];
                  end
               end
            end
`ifdef CFG_ENTRY_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d = S_ERROR;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
`endif
         end
         S_CHECK: begin
            if (cmdAbort) begin
               state_d = S_IDLE;
            end else if (range_ok) begin
               state_d = S_WAIT_SAFE;
            end else begin
               state_d = S_ERROR;
               error_d = 1'b1;
            end
         end
         S_WAIT_SAFE: begin
            if (cmdAbort) begin
               state_d = S_IDLE;
            end else if (commitAllowed) begin
               state_d  = S_WRITE;
               wr_idx_d = 3'd0;
            end
         end
         S_WRITE: begin
            // Runs to completion regardless of commitAllowed, abort or start.
            if (wr_idx_q < 3'd6) begin
               sel_d    = 6'b100000 >> wr_idx_q;
               dout_d   = shadow_q[wr_idx_q];
               wr_idx_d = wr_idx_q + 3'd1;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Control state and registered outputs with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         wr_idx_q <= 3'd0;
         sel_q    <= 6'd0;
         dout_q   <= 4'd0;
         busy_q   <= 1'b0;
         stage_q  <= 2'd0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef CFG_ENTRY_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_idx_q <= wr_idx_d;
         sel_q    <= sel_d;
         dout_q   <= dout_d;
         busy_q   <= busy_d;
         stage_q  <= stage_d;
         done_q   <= done_d;
         error_q  <= error_d;
`ifdef CFG_ENTRY_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   // Shadow digits need no reset: every sequence rewrites all six before use.
   always_ff @(posedge clock) begin
      shadow_q <= shadow_d;
   end

   assign RegisterSelect = sel_q;
   assign dataOut        = dout_q;
   assign busy           = busy_q;
   assign stage          = stage_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_traffic_timing_loader.sv
// Directed bench for traffic_timing_loader: expected register-bank writes and
// done pulses are queued by the stimulus; a negedge monitor pops and compares.
module tb_traffic_timing_loader;

   localparam int TMO = 50;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmdStart;
   logic       cmdAbort;
   logic       digitValid;
   logic [3:0] dataIn;
   logic       commitAllowed;
   logic [5:0] RegisterSelect;
   logic [3:0] dataOut;
   logic       busy;
   logic [1:0] stage;
   logic       done;
   logic       error;

   typedef struct packed {
      logic [5:0] sel;
      logic [3:0] data;
   } wr_t;

   wr_t  exp_wr[$];
   logic exp_done[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   traffic_timing_loader #(
      .MIN_TIME(5),
      .MAX_TIME(99),
      .ENTRY_TIMEOUT(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .cmdStart(cmdStart),
      .cmdAbort(cmdAbort),
      .digitValid(digitValid),
      .dataIn(dataIn),
      .commitAllowed(commitAllowed),
      .RegisterSelect(RegisterSelect),
      .dataOut(dataOut),
      .busy(busy),
      .stage(stage),
      .done(done),
      .error(error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every write pulse and done pulse must match the queued expectation.
   always @(negedge clock) begin
      wr_t  e;
      logic de;
      if (RegisterSelect != 6'd0) begin
         if (exp_wr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: sel=%b data=%0d, expected no write", RegisterSelect, dataOut);
         end else begin
            e = exp_wr.pop_front();
            check("write_sel", 32'(RegisterSelect), 32'(e.sel));
            check("write_data", 32'(dataOut), 32'(e.data));
         end
      end
      if (done) begin
         if (exp_done.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: done=1, expected 0");
         end else begin
            de = exp_done.pop_front();
            check("done_error", 32'(error), 32'(de));
         end
      end
   end

   task automatic pulse_start();
      @(negedge clock);
      cmdStart = 1'b1;
      @(negedge clock);
      cmdStart = 1'b0;
   endtask

   task automatic send_digit(input logic [3:0] d, input logic abort);
      @(negedge clock);
      digitValid = 1'b1;
      dataIn     = d;
      cmdAbort   = abort;
      @(negedge clock);
      digitValid = 1'b0;
      cmdAbort   = 1'b0;
   endtask

   task automatic send6(input logic [23:0] ds);
      for (int i = 0; i < 6; i++) send_digit(ds[23-4*i -: 4], 1'b0);
   endtask

   task automatic push_writes(input logic [23:0] ds, input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.sel  = 6'b100000 >> i;
         w.data = ds[23-4*i -: 4];
         exp_wr.push_back(w);
      end
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < 30 && !done; k++) @(negedge clock);
      check(name, 32'(done), 32'd1);
   endtask

   task automatic wait_sel(input string name, input logic [5:0] s);
      for (int k = 0; k < 12 && RegisterSelect != s; k++) @(negedge clock);
      check(name, 32'(RegisterSelect), 32'(s));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_sel"}, 32'(RegisterSelect), 32'd0);
      check({name, "_dout"}, 32'(dataOut), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_stage"}, 32'(stage), 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_error"}, 32'(error), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      cmdStart      = 1'b0;
      cmdAbort      = 1'b0;
      digitValid    = 1'b0;
      dataIn        = 4'd0;
      commitAllowed = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;

      // T1: nominal 30/20/05 programming with commit already allowed.
      commitAllowed = 1'b1;
      push_writes(24'h302005, 6);
      exp_done.push_back(1'b0);
      pulse_start();
      check("t1_busy_after_start", 32'(busy), 32'd1);
      send6(24'h302005);
      check("t1_busy_in_check", 32'(busy), 32'd1);
      check("t1_stage_ta", 32'(stage), 32'd2);
      @(negedge clock);
      check("t1_no_write_wait_safe", 32'(RegisterSelect), 32'd0);
      @(negedge clock);
      check("t1_no_write_write_entry", 32'(RegisterSelect), 32'd0);
      @(negedge clock);
      check("t1_first_write_latency", 32'(RegisterSelect), 32'h20);
      wait_done("t1_done");
      check("t1_error", 32'(error), 32'd0);
      check("t1_busy_after_done", 32'(busy), 32'd0);
      @(negedge clock);
      check("t1_writes_consumed", 32'(exp_wr.size()), 32'd0);

      // T2: Ta = 03 is below the minimum.
      pulse_start();
      send6(24'h302003);
      check("t2_error_in_check", 32'(error), 32'd0);
      @(negedge clock);
      check("t2_error_set", 32'(error), 32'd1);
      @(negedge clock);
      check("t2_busy_cleared", 32'(busy), 32'd0);
      check("t2_error_sticky", 32'(error), 32'd1);

      // T3: hold in WAIT_SAFE, then commit; drop commitAllowed mid-write.
      commitAllowed = 1'b0;
      pulse_start();
      check("t3_error_cleared", 32'(error), 32'd0);
      check("t3_stage_tpv", 32'(stage), 32'd0);
      send_digit(4'd1, 1'b0);
      send_digit(4'd5, 1'b0);
      check("t3_stage_tsv", 32'(stage), 32'd1);
      send_digit(4'd2, 1'b0);
      send_digit(4'd0, 1'b0);
      check("t3_stage_ta", 32'(stage), 32'd2);
      send_digit(4'd0, 1'b0);
      send_digit(4'd7, 1'b0);
      repeat (20) @(negedge clock);
      check("t3_busy_waiting", 32'(busy), 32'd1);
      check("t3_no_write_waiting", 32'(RegisterSelect), 32'd0);
      push_writes(24'h152007, 6);
      exp_done.push_back(1'b0);
      commitAllowed = 1'b1;
      @(negedge clock);
      check("t3_no_write_at_commit", 32'(RegisterSelect), 32'd0);
      @(negedge clock);
      check("t3_first_write", 32'(RegisterSelect), 32'h20);
      commitAllowed = 1'b0;
      wait_done("t3_done");
      check("t3_busy_after_done", 32'(busy), 32'd0);

      // T4: illegal digit 0xA as third digit.
      pulse_start();
      send_digit(4'd1, 1'b0);
      send_digit(4'd2, 1'b0);
      send_digit(4'hA, 1'b0);
      check("t4_error_set", 32'(error), 32'd1);
      check("t4_busy_in_error", 32'(busy), 32'd1);
      @(negedge clock);
      check("t4_busy_cleared", 32'(busy), 32'd0);
      pulse_start();
      check("t4_error_cleared_by_start", 32'(error), 32'd0);
      @(negedge clock);
      cmdAbort = 1'b1;
      @(negedge clock);
      cmdAbort = 1'b0;
      check("t4_abort_idle", 32'(busy), 32'd0);

      // T5: abort with fourth digit, start ignored during WRITE, reset mid-WRITE.
      commitAllowed = 1'b1;
      pulse_start();
      send_digit(4'd1, 1'b0);
      send_digit(4'd2, 1'b0);
      send_digit(4'd3, 1'b0);
      send_digit(4'd4, 1'b1);
      check("t5_abort_busy", 32'(busy), 32'd0);
      check("t5_abort_error", 32'(error), 32'd0);
      push_writes(24'h452510, 6);
      exp_done.push_back(1'b0);
      pulse_start();
      send6(24'h452510);
      wait_sel("t5_write_started", 6'h20);
      cmdStart = 1'b1;
      @(negedge clock);
      cmdStart = 1'b0;
      wait_done("t5_done_despite_start");
      @(negedge clock);
      check("t5_start_ignored", 32'(busy), 32'd0);
      push_writes(24'h606060, 3);
      pulse_start();
      send6(24'h606060);
      wait_sel("t5_third_write", 6'h08);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("t5_reset_mid_write");
      reset = 1'b0;
      check("t5_writes_consumed", 32'(exp_wr.size()), 32'd0);

      // T6: entry idle behaviour.
      commitAllowed = 1'b0;
      pulse_start();
      send_digit(4'd1, 1'b0);
      send_digit(4'd2, 1'b0);
`ifdef CFG_ENTRY_TIMEOUT_EN
      repeat (TMO - 1) @(negedge clock);
      check("t6_no_timeout_yet", 32'(error), 32'd0);
      check("t6_busy_before_timeout", 32'(busy), 32'd1);
      @(negedge clock);
      check("t6_timeout_error", 32'(error), 32'd1);
      @(negedge clock);
      check("t6_idle_after_timeout", 32'(busy), 32'd0);
`else
      repeat (200) @(negedge clock);
      check("t6_still_busy", 32'(busy), 32'd1);
      check("t6_no_error", 32'(error), 32'd0);
      @(negedge clock);
      cmdAbort = 1'b1;
      @(negedge clock);
      cmdAbort = 1'b0;
      check("t6_abort_idle", 32'(busy), 32'd0);
`endif

      @(negedge clock);
      check("final_writes_empty", 32'(exp_wr.size()), 32'd0);
      check("final_done_empty", 32'(exp_done.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/traffic_timing_loader.md
# traffic_timing_loader

Controller that programs the traffic-light timing register bank (Tpv, Tsv, Ta) from a 4-bit BCD keypad stream. It collects six digits, range-checks the three two-digit times, waits until the semaphore controller reports a safe point, then sequences one-hot writes into the register bank via `RegisterSelect`/`dataOut`. It sits between the operator input and the register bank, next to the semaphore control unit, and runs on the fast system clock.

## Interface

- `MIN_TIME`, 5: minimum legal time, in seconds, for Tpv, Tsv and Ta.
- `MAX_TIME`, 99: maximum legal time, in seconds.
- `ENTRY_TIMEOUT`, 1000: idle-cycle limit during entry; used only with `CFG_ENTRY_TIMEOUT_EN`.
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `cmdStart` in 1: single-cycle request to begin a programming sequence.
- `cmdAbort` in 1: single-cycle request to cancel a sequence.
- `digitValid` in 1: single-cycle strobe qualifying `dataIn`.
- `dataIn` in 4: BCD digit from the keypad.
- `commitAllowed` in 1: from the semaphore control unit; high when register updates are safe.
- `RegisterSelect` out 6: one-hot register-bank write select. Bit 5 is Tpv tens, bit 4 Tpv units, bit 3 Tsv tens, bit 2 Tsv units, bit 1 Ta tens, bit 0 Ta units.
- `dataOut` out 4: digit driven to the register bank; valid while `RegisterSelect` is non-zero.
- `busy` out 1: high in every state except IDLE.
- `stage` out 2: register being entered. 0 is Tpv, 1 is Tsv, 2 is Ta.
- `done` out 1: one-cycle pulse after the last write.
- `error` out 1: sticky error flag; cleared by the next accepted `cmdStart` or by reset.

## Operation

- States: IDLE, ENTRY, CHECK, WAIT_SAFE, WRITE, ERROR.
- **IDLE**
  - `cmdStart` moves to ENTRY.
  - On entering ENTRY: clear `error`, clear the digit count, set `stage`=0.
  - `digitValid` in IDLE is ignored.
- **ENTRY**
  - Each `digitValid` stores `dataIn` into shadow slot 0..5, in `RegisterSelect` bit order (tens first).
  - `stage` = count/2.
  - A digit greater than 9 goes to ERROR; the digit is not stored.
  - After the sixth valid digit, go to CHECK.
- **CHECK** (1 cycle)
  - Compute each value as tens*10+units, 7 bits unsigned.
  - Any value outside [`MIN_TIME`, `MAX_TIME`] goes to ERROR; otherwise go to WAIT_SAFE.
- **WAIT_SAFE**
  - Hold until `commitAllowed` is sampled high, then go to WRITE.
- **WRITE** (6 cycles)
  - `RegisterSelect` walks from bit 5 down to bit 0, one bit per cycle.
  - `dataOut` carries the matching shadow digit.
  - Then go to IDLE with `done` pulsed.
  - Once WRITE has started, it completes even if `commitAllowed` drops.
- **ERROR** (1 cycle)
  - Set `error`=1 and go to IDLE.
  - Nothing is written to the register bank.
- **Abort**
  - `cmdAbort` in ENTRY, CHECK or WAIT_SAFE goes to IDLE next cycle, with no writes and `error` unchanged.
  - `cmdAbort` is ignored in WRITE, ERROR and IDLE.
- **Simultaneous and ignored events**
  - `cmdAbort` together with `digitValid`: abort wins and the digit is discarded.
  - `cmdStart` while `busy` is ignored.
  - `cmdStart` together with `cmdAbort` in IDLE: start wins.
- Shadow digits are not cleared between sequences; every sequence overwrites all six slots before they are used.

## Timing

- All outputs are registered.
- Reset values: `RegisterSelect`=0, `dataOut`=0, `busy`=0, `stage`=0, `done`=0, `error`=0; state is IDLE.
- `cmdStart` sampled at edge N: `busy`=1 from N.
- Sixth digit sampled at edge N: CHECK at N, WAIT_SAFE at N+1.
- `commitAllowed` sampled high at edge M in WAIT_SAFE:
  - `RegisterSelect`=6'b100000 after M+1.
  - 6'b000001 after M+6.
  - `RegisterSelect`=0, `done`=1 and `busy`=0 after M+7.
- Best-case latency from the sixth digit to the first write is 3 cycles.
- Reset in any state, including mid-WRITE, takes effect at the next edge. Register-bank slots already written stay written, since the bank has its own reset.

## Configuration

- `CFG_ENTRY_TIMEOUT_EN` defined:
  - In ENTRY, a counter clears on every `digitValid`.
  - After `ENTRY_TIMEOUT` consecutive cycles without a digit, go to ERROR, which sets `error`.
- `CFG_ENTRY_TIMEOUT_EN` undefined: ENTRY waits indefinitely and no counter is synthesised.

## Test plan

- Reset, then `cmdStart` and digits 3,0,2,0,0,5; `commitAllowed`=1 → `RegisterSelect` pulses 32,16,8,4,2,1 with `dataOut` 3,0,2,0,0,5, then `done`=1 and `error`=0.
- Digits 3,0,2,0,0,3 (Ta=3 < 5) → `error`=1, `RegisterSelect` never non-zero, `busy`=0 two cycles after the sixth digit.
- Valid entry with `commitAllowed`=0 for 20 cycles, then 1 → WAIT_SAFE holds and `busy`=1; first write pulse 1 cycle after `commitAllowed` is sampled high. Drop `commitAllowed` during WRITE → all 6 writes still occur.
- Digit 4'hA as the third digit → `error`=1 next cycle, no writes. Next `cmdStart` → `error`=0.
- `cmdAbort` together with the fourth `digitValid` → IDLE, no writes, `error`=0. `cmdStart` during WRITE is ignored. Reset at the third write cycle → all outputs 0 the next cycle.
- With `CFG_ENTRY_TIMEOUT_EN` and `ENTRY_TIMEOUT`=50: two digits, then silence → `error`=1 after 50 idle cycles. Without the macro: still `busy` after 200 cycles.
